// File: rtl/alu_writeback.sv
// alu_writeback: consumer end of the ALU result interface.
// Accepts result beats through valid/ready, buffers them in a 2-entry queue,
// and commits one beat per cycle into an 8x16 register file and a 5-bit flag
// register. Provides two combinational operand read ports back to the ALU.
// Optional feature macro: ALU_WB_FORWARD_EN (read ports forward pending queue
// entries; youngest entry wins over oldest, oldest over the register file).
module alu_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] addr_out,
  input  logic [1:0]        alu_ot,
  input  logic              za,
  input  logic              zb,
  input  logic              eq,
  input  logic              gt,
  input  logic              lt,
  input  logic              wb_hold,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [4:0]        flags,
  output logic              busy,
  output logic              wb_commit
);

  localparam logic [1:0] OtNone  = 2'b11;
  localparam logic [1:0] OtLogic = 2'b10;

  // Queue storage: slot 0 is always the head, slot 1 the younger entry.
  logic [DATA_W-1:0] q_data_q [2];
  logic [ADDR_W-1:0] q_addr_q [2];
  logic [1:0]        q_ot_q   [2];
  logic [4:0]        q_flg_q  [2];
  logic [DATA_W-1:0] q_data_d [2];
  logic [ADDR_W-1:0] q_addr_d [2];
  logic [1:0]        q_ot_d   [2];
  logic [4:0]        q_flg_d  [2];
  logic [1:0]        count_q, count_d;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [4:0]        flags_q;
  logic              commit_q;

  logic              accept;
  logic              push;
  logic              pop;
  logic [4:0]        in_flags;

  assign in_flags  = {za, zb, eq, gt, lt};
  assign wb_ready  = (count_q < 2'd2);
  assign accept    = wb_valid && wb_ready;
  // Type-11 beats complete the handshake but are dropped here.
  assign push      = accept && (alu_ot != OtNone);
  assign pop       = (count_q != 2'd0) && !wb_hold;
  assign busy      = (count_q != 2'd0);
  assign flags     = flags_q;
  assign wb_commit = commit_q;

  // Queue next-state: shift on pop, append new beat behind any survivor.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_data_d[i] = q_data_q[i];
      q_addr_d[i] = q_addr_q[i];
      q_ot_d[i]   = q_ot_q[i];
      q_flg_d[i]  = q_flg_q[i];
    end
    count_d = count_q;
    if (pop) begin
      q_data_d[0] = q_data_q[1];
      q_addr_d[0] = q_addr_q[1];
      q_ot_d[0]   = q_ot_q[1];
      q_flg_d[0]  = q_flg_q[1];
    end
    if (push) begin
      // Slot for the new beat is the post-pop occupancy.
      if ((pop ? count_q - 2'd1 : count_q) == 2'd0) begin
        q_data_d[0] = alu_out;
        q_addr_d[0] = addr_out;
        q_ot_d[0]   = alu_ot;
        q_flg_d[0]  = in_flags;
      end else begin
        q_data_d[1] = alu_out;
        q_addr_d[1] = addr_out;
        q_ot_d[1]   = alu_ot;
        q_flg_d[1]  = in_flags;
      end
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Queue state and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data_q[i] <= '0;
        q_addr_q[i] <= '0;
        q_ot_q[i]   <= OtNone;
        q_flg_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < 2; i++) begin
        q_data_q[i] <= q_data_d[i];
        q_addr_q[i] <= q_addr_d[i];
        q_ot_q[i]   <= q_ot_d[i];
        q_flg_q[i]  <= q_flg_d[i];
      end
    end
  end

  // Commit the head into the register file and, for logic/compare beats, the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      flags_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= pop;
      if (pop) begin
        regs_q[q_addr_q[0]] <= q_data_q[0];
        if (q_ot_q[0] == OtLogic) begin
          flags_q <= q_flg_q[0];
        end
      end
    end
  end

`ifdef ALU_WB_FORWARD_EN
  logic hit_a0, hit_a1, hit_b0, hit_b1;

  assign hit_a0 = (count_q != 2'd0) && (q_ot_q[0] != OtNone) && (q_addr_q[0] == rd_addr_a);
  assign hit_a1 = (count_q == 2'd2) && (q_ot_q[1] != OtNone) && (q_addr_q[1] == rd_addr_a);
  assign hit_b0 = (count_q != 2'd0) && (q_ot_q[0] != OtNone) && (q_addr_q[0] == rd_addr_b);
  assign hit_b1 = (count_q == 2'd2) && (q_ot_q[1] != OtNone) && (q_addr_q[1] == rd_addr_b);

  // Operand reads with forwarding: youngest pending entry, then head, then regfile.
  always_comb begin
    op1 = regs_q[rd_addr_a];
    op2 = regs_q[rd_addr_b];
    if (hit_a1) begin
      op1 = q_data_q[1];
    end else if (hit_a0) begin
      op1 = q_data_q[0];
    end
    if (hit_b1) begin
      op2 = q_data_q[1];
    end else if (hit_b0) begin
      op2 = q_data_q[0];
    end
  end
`else
  // Operand reads straight from the register file; decode stalls on busy.
  always_comb begin
    op1 = regs_q[rd_addr_a];
    op2 = regs_q[rd_addr_b];
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] alu_out;
  logic [2:0]  addr_out;
  logic [1:0]  alu_ot;
  logic        za, zb, eq, gt, lt;
  logic        wb_hold;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [4:0]  flags;
  logic        busy;
  logic        wb_commit;

  int checks = 0;
  int failures = 0;

  alu_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .alu_out   (alu_out),
    .addr_out  (addr_out),
    .alu_ot    (alu_ot),
    .za        (za),
    .zb        (zb),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .wb_hold   (wb_hold),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .op1       (op1),
    .op2       (op2),
    .flags     (flags),
    .busy      (busy),
    .wb_commit (wb_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle at +1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic [2:0] a, input logic [1:0] ot,
                      input logic [4:0] f);
    wb_valid = 1'b1;
    alu_out  = d;
    addr_out = a;
    alu_ot   = ot;
    {za, zb, eq, gt, lt} = f;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; alu_out = '0; addr_out = '0; alu_ot = 2'b11;
    {za, zb, eq, gt, lt} = 5'b0; wb_hold = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

    // Reset state: every register reads zero on both ports.
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      check($sformatf("reset_op1_r%0d", i), 32'(op1), 32'h0);
      check($sformatf("reset_op2_r%0d", 7 - i), 32'(op2), 32'h0);
    end
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_ready", 32'(wb_ready), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_commit", 32'(wb_commit), 32'h0);
    rst_n = 1'b1;
    step();

    // Single arithmetic beat to r3.
    rd_addr_a = 3'd3;
    beat(16'h1234, 3'd3, 2'b01, 5'b11111);
    step();                                   // edge N: accepted
    wb_valid = 1'b0;
    check("single_busy_n1", 32'(busy), 32'h1);
    check("single_commit_n1", 32'(wb_commit), 32'h0);
`ifdef ALU_WB_FORWARD_EN
    check("single_op1_n1", 32'(op1), 32'h1234);
`else
    check("single_op1_n1", 32'(op1), 32'h0);
`endif
    step();                                   // edge N+1: commit
    check("single_commit_n2", 32'(wb_commit), 32'h1);
    check("single_op1_n2", 32'(op1), 32'h1234);
    check("single_busy_n2", 32'(busy), 32'h0);
    check("single_flags", 32'(flags), 32'h0);
    step();
    check("single_commit_pulse_end", 32'(wb_commit), 32'h0);

    // Hold with three back-to-back beats to r1, r2, r3.
    wb_hold = 1'b1;
    rd_addr_a = 3'd1;
    rd_addr_b = 3'd2;
    beat(16'h0101, 3'd1, 2'b01, 5'b0);
    step();
    check("hold_ready_after1", 32'(wb_ready), 32'h1);
    beat(16'h0202, 3'd2, 2'b01, 5'b0);
    step();
    check("hold_ready_after2", 32'(wb_ready), 32'h0);
    beat(16'h0303, 3'd3, 2'b01, 5'b0);
    step();                                   // third beat not taken: full
    check("hold_ready_full", 32'(wb_ready), 32'h0);
    check("hold_no_commit", 32'(wb_commit), 32'h0);
    check("hold_busy", 32'(busy), 32'h1);
`ifdef ALU_WB_FORWARD_EN
    check("hold_fwd_r1", 32'(op1), 32'h0101);
`else
    check("hold_r1_unwritten", 32'(op1), 32'h0);
`endif
    wb_hold = 1'b0;
    step();                                   // commit r1; beat 3 still waiting
    check("rel_commit1", 32'(wb_commit), 32'h1);
    check("rel_r1", 32'(op1), 32'h0101);
`ifdef ALU_WB_FORWARD_EN
    check("rel_r2_pending", 32'(op2), 32'h0202);
`else
    check("rel_r2_pending", 32'(op2), 32'h0);
`endif
    check("rel_ready", 32'(wb_ready), 32'h1);
    step();                                   // commit r2, accept beat 3
    wb_valid = 1'b0;
    check("rel_r2", 32'(op2), 32'h0202);
    check("rel_busy_mid", 32'(busy), 32'h1);
    rd_addr_a = 3'd3;
    step();                                   // commit r3
    check("rel_r3", 32'(op1), 32'h0303);
    check("rel_commit3", 32'(wb_commit), 32'h1);
    check("rel_busy_end", 32'(busy), 32'h0);

    // Logic beat updates flags; a following arithmetic beat keeps them.
    rd_addr_a = 3'd5;
    beat(16'h0055, 3'd5, 2'b10, 5'b00101);
    step();
    wb_valid = 1'b0;
    step();
    check("logic_flags", 32'(flags), 32'h05);
    check("logic_r5", 32'(op1), 32'h0055);
    rd_addr_a = 3'd0;
    beat(16'h0F0F, 3'd0, 2'b01, 5'b11010);
    step();
    wb_valid = 1'b0;
    step();
    check("arith_flags_held", 32'(flags), 32'h05);
    check("arith_r0", 32'(op1), 32'h0F0F);

    // Write-after-write to r6 under hold.
    wb_hold = 1'b1;
    rd_addr_a = 3'd6;
    beat(16'hAAAA, 3'd6, 2'b01, 5'b0);
    step();
    beat(16'h5555, 3'd6, 2'b01, 5'b0);
    step();
    wb_valid = 1'b0;
`ifdef ALU_WB_FORWARD_EN
    check("waw_pending", 32'(op1), 32'h5555);
`else
    check("waw_pending", 32'(op1), 32'h0);
`endif
    wb_hold = 1'b0;
    step();
`ifdef ALU_WB_FORWARD_EN
    check("waw_after_first", 32'(op1), 32'h5555);
`else
    check("waw_after_first", 32'(op1), 32'hAAAA);
`endif
    step();
    check("waw_final", 32'(op1), 32'h5555);
    check("waw_busy", 32'(busy), 32'h0);

    // Reset with a full, held queue.
    wb_hold = 1'b1;
    beat(16'h7777, 3'd7, 2'b10, 5'b11111);
    step();
    beat(16'h4444, 3'd4, 2'b01, 5'b0);
    step();
    wb_valid = 1'b0;
    check("pre_reset_full", 32'(wb_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 32'h0);
    check("async_reset_ready", 32'(wb_ready), 32'h1);
    wb_hold = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("post_reset_commit", 32'(wb_commit), 32'h0);
    step();
    check("post_reset_commit2", 32'(wb_commit), 32'h0);
    check("post_reset_flags", 32'(flags), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1;
      check($sformatf("post_reset_r%0d", i), 32'(op1), 32'h0);
    end

    // Type-11 beat: handshake completes, nothing is written.
    rd_addr_a = 3'd4;
    beat(16'hFFFF, 3'd4, 2'b11, 5'b11111);
    #1;
    check("none_ready", 32'(wb_ready), 32'h1);
    step();
    wb_valid = 1'b0;
    check("none_busy", 32'(busy), 32'h0);
    check("none_commit1", 32'(wb_commit), 32'h0);
    check("none_r4_fwd", 32'(op1), 32'h0);
    step();
    check("none_commit2", 32'(wb_commit), 32'h0);
    check("none_r4", 32'(op1), 32'h0);
    check("none_flags", 32'(flags), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Consumer end of the ALU result interface in the 16-bit CPU.
- Accepts ALU result beats (data, 3-bit destination register address, output-type code, compare flags) through a valid/ready handshake.
- Buffers them in a 2-entry queue and commits one per cycle into an 8x16 register file and a 5-bit flag register.
- Provides the two combinational operand read ports (op1/op2) that feed back into the ALU.

Parameters:
- DATA_W, 16, register and result width
- NREGS, 8, number of architectural registers
- ADDR_W, 3, register address width (log2 NREGS)
- QDEPTH, 2, writeback queue depth (fixed at 2; other values unsupported)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  ALU beat valid
- wb_ready  output  1  queue can accept a beat
- alu_out  input  DATA_W  result data
- addr_out  input  ADDR_W  destination register
- alu_ot  input  2  output type: 00 addressing/move, 01 arithmetic, 10 logic/compare, 11 none
- za, zb, eq, gt, lt  input  1 each  ALU compare flags
- wb_hold  input  1  stall commit (e.g. memory port busy)
- rd_addr_a  input  ADDR_W  read port A address
- rd_addr_b  input  ADDR_W  read port B address
- op1  output  DATA_W  register[rd_addr_a]
- op2  output  DATA_W  register[rd_addr_b]
- flags  output  5  {za,zb,eq,gt,lt} committed flag register
- busy  output  1  queue non-empty
- wb_commit  output  1  pulse: a register write happened this edge

Behaviour:
- Reset (rst_n low, async):
  - all registers = 0, flags = 0, queue count = 0, wb_commit = 0.
  - Pending beats are discarded. Release is synchronous to the next clk edge.
- Handshake:
  - A beat is accepted on a rising edge with wb_valid && wb_ready.
  - wb_ready = (count < 2); it is combinational from count only and never depends on wb_valid.
  - No push when full, even if a pop occurs in the same cycle.
- Accept filter: beats with alu_ot == 11 are accepted (consumed) but not enqueued and cause no write.
- Queue: 2-entry FIFO, entries {data, addr, ot, flags5}. Count range 0..2.
  - Simultaneous push and pop (count 1 or 2-not-full case) leaves count unchanged; order is preserved.
- Commit:
  - On each edge where count > 0 and wb_hold == 0, the head is written: regfile[head.addr] = head.data.
  - If head.ot == 10, flags also update to head.flags5; otherwise flags are held.
  - wb_commit is registered and is high in the cycle following the commit edge.
  - wb_hold == 1 freezes the head; pushes continue until the queue is full.
- Latency:
  - Beat accepted at edge N commits at edge N+1 (empty queue, no hold).
  - It is visible on op1/op2 from cycle N+2 without forwarding.
- Read ports: combinational. Register 0 is an ordinary writable register.
- Write-after-write to the same address: the later beat wins; commit order equals accept order.
- busy = (count != 0).

Optional Feature:
- Macro: ALU_WB_FORWARD_EN.
- Defined:
  - op1/op2 forward from pending queue entries whose addr matches and whose ot != 11.
  - Priority: youngest queue entry > oldest > regfile.
  - A beat accepted at edge N is visible on the read ports from cycle N+1.
  - flags output is unaffected (committed value only).
- Undefined:
  - Read ports return regfile contents only.
  - The decode stage must stall on busy to avoid hazards.

Test Plan:
- Reset then read all 8 addresses -> op1 = op2 = 0x0000, flags = 0, wb_ready = 1, busy = 0.
- Single beat alu_out=0x1234, addr_out=3, alu_ot=01 with wb_hold=0 -> wb_commit pulses. Then:
  - rd_addr_a=3 gives 0x1234 at N+2.
  - With ALU_WB_FORWARD_EN, it gives 0x1234 at N+1.
  - flags unchanged.
- wb_hold=1 with three back-to-back beats (addr 1, 2, 3):
  - wb_ready drops after the second beat.
  - The third beat is held by the source.
  - Release hold -> commits in order 1, 2, 3; count returns to 0.
- Logic beat alu_ot=10, {za,zb,eq,gt,lt}=00101, addr 5 -> flags = 5'b00101 after commit. A following alu_ot=01 beat leaves flags at 00101.
- Same-address write-after-write: 0xAAAA then 0x5555 to addr 6 -> final reg6 = 0x5555. With forwarding, reads during the pending window return 0x5555 once the second beat is accepted.
- Assert rst_n low while count=2 and wb_hold=1 -> immediately count=0, busy=0, no commit after release, reg contents all 0.
- Beat with alu_ot=11, addr 4, data 0xFFFF -> accepted (handshake completes), busy stays 0, reg4 stays 0, no wb_commit.
